// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
package mc_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned SEL_W   = 2;

    // State encodings are visible on the debug port, so they are fixed.
    localparam logic [STATE_W-1:0] ST_IF  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ID  = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXE = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM = 3'd3;
    localparam logic [STATE_W-1:0] ST_WB  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = ST_IF,
        S_ID  = ST_ID,
        S_EXE = ST_EXE,
        S_MEM = ST_MEM,
        S_WB  = ST_WB
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL = 6'h02;
    localparam logic [OP_W-1:0] FN_SRA = 6'h03;
    localparam logic [OP_W-1:0] FN_JR  = 6'h08;
    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR = 6'h26;

    // Don't-care top bit of the non-shift codes is tied to 0.
    localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_INC   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JR     = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b11;

    typedef struct packed {
        logic              rtype;
        logic              itype_alu;
        logic              is_lw;
        logic              is_sw;
        logic              is_br;
        logic              is_bne;
        logic              is_j;
        logic              is_jal;
        logic              is_jr;
        logic              is_shift;
        logic              ill;
        logic              imm_sext;
        logic [ALUC_W-1:0] alu_op;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decoder producing instruction-class flags and ALU op.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALUC_ADD;
        case (op)
            OP_RTYPE: begin
                dec.rtype = 1'b1;
                case (func)
                    FN_ADD: dec.alu_op = ALUC_ADD;
                    FN_SUB: dec.alu_op = ALUC_SUB;
                    FN_AND: dec.alu_op = ALUC_AND;
                    FN_OR:  dec.alu_op = ALUC_OR;
                    FN_XOR: dec.alu_op = ALUC_XOR;
                    FN_SLL: begin dec.alu_op = ALUC_SLL; dec.is_shift = 1'b1; end
                    FN_SRL: begin dec.alu_op = ALUC_SRL; dec.is_shift = 1'b1; end
                    FN_SRA: begin dec.alu_op = ALUC_SRA; dec.is_shift = 1'b1; end
                    FN_JR:  begin dec.rtype = 1'b0; dec.is_jr = 1'b1; end
                    default: begin dec.rtype = 1'b0; dec.ill = 1'b1; end
                endcase
            end
            OP_ADDI: begin dec.itype_alu = 1'b1; dec.imm_sext = 1'b1; end
            OP_ANDI: begin dec.itype_alu = 1'b1; dec.alu_op = ALUC_AND; end
            OP_ORI:  begin dec.itype_alu = 1'b1; dec.alu_op = ALUC_OR; end
            OP_XORI: begin dec.itype_alu = 1'b1; dec.alu_op = ALUC_XOR; end
            OP_LUI:  begin dec.itype_alu = 1'b1; dec.alu_op = ALUC_LUI; end
            OP_LW:   begin dec.is_lw = 1'b1; dec.imm_sext = 1'b1; end
            OP_SW:   begin dec.is_sw = 1'b1; dec.imm_sext = 1'b1; end
            OP_BEQ:  dec.is_br = 1'b1;
            OP_BNE:  begin dec.is_br = 1'b1; dec.is_bne = 1'b1; end
            OP_J:    dec.is_j = 1'b1;
            OP_JAL:  dec.is_jal = 1'b1;
            default: dec.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) with Mealy output decode.
// Optional MC_MEM_WAIT_EN adds mem_rdy and stalls IF/MEM until memory is ready.
module mc_ctrl_unit
    import mc_pkg::*;
#(
    parameter logic [1:0] PC_INC_SEL = 2'b01
)(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       jal,
    output logic       sext,
    output logic [2:0] state,
    output logic       ill
`ifdef MC_MEM_WAIT_EN
    ,
    input  logic       mem_rdy
`endif
);

    state_t state_q;
    state_t state_d;
    dec_t   dec;
    logic   mem_ok;
    logic   pc_en;
    logic   ir_en;
    logic   mem_en;
    logic   reg_en;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_rdy;
`else
    assign mem_ok = 1'b1;
`endif

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control, decoded from state and the current IR.
    always_comb begin
        state_d = S_IF;
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        mem_en  = 1'b0;
        reg_en  = 1'b0;
        iord    = 1'b0;
        regrt   = 1'b0;
        m2reg   = 1'b0;
        aluc    = ALUC_ADD;
        shift   = 1'b0;
        alusrca = 1'b0;
        alusrcb = SRCB_B;
        pcsrc   = PCSRC_ALU;
        jal     = 1'b0;
        sext    = 1'b0;
        ill     = 1'b0;
        case (state_q)
            S_IF: begin
                pc_en   = mem_ok;
                ir_en   = mem_ok;
                alusrcb = PC_INC_SEL;
                state_d = mem_ok ? S_ID : S_IF;
            end
            S_ID: begin
                // ALUout takes the branch target while the class is resolved.
                alusrcb = SRCB_IMMSH;
                sext    = 1'b1;
                if (dec.ill) begin
                    ill     = 1'b1;
                    state_d = S_IF;
                end else if (dec.is_j || dec.is_jal) begin
                    pc_en   = 1'b1;
                    pcsrc   = PCSRC_JUMP;
                    reg_en  = dec.is_jal;
                    jal     = dec.is_jal;
                    state_d = S_IF;
                end else if (dec.is_jr) begin
                    pc_en   = 1'b1;
                    pcsrc   = PCSRC_JR;
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                if (dec.is_br) begin
                    aluc    = ALUC_SUB;
                    pcsrc   = PCSRC_ALUOUT;
                    pc_en   = dec.is_bne ? ~zero : zero;
                    state_d = S_IF;
                end else if (dec.is_lw || dec.is_sw) begin
                    alusrcb = SRCB_IMM;
                    sext    = dec.imm_sext;
                    state_d = S_MEM;
                end else if (dec.itype_alu) begin
                    alusrcb = SRCB_IMM;
                    sext    = dec.imm_sext;
                    aluc    = dec.alu_op;
                    state_d = S_WB;
                end else begin
                    shift   = dec.is_shift;
                    aluc    = dec.alu_op;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (dec.is_sw) begin
                    mem_en  = mem_ok;
                    state_d = mem_ok ? S_IF : S_MEM;
                end else begin
                    state_d = mem_ok ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                reg_en  = 1'b1;
                regrt   = ~dec.rtype;
                m2reg   = dec.is_lw;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Architectural enables are suppressed for as long as reset is held.
    assign wpc   = pc_en & clrn;
    assign wir   = ir_en & clrn;
    assign wmem  = mem_en & clrn;
    assign wreg  = reg_en & clrn;
    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit against an instruction-level reference model.
module tb_mc_ctrl_unit;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] func = 6'h20;
    logic       zero = 1'b0;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext, ill;
    logic [3:0] aluc;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] state;
`ifdef MC_MEM_WAIT_EN
    logic       mem_rdy = 1'b1;
`endif

    int errors = 0;
    int checks = 0;

    mc_ctrl_unit dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .zero(zero),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .regrt(regrt), .m2reg(m2reg), .aluc(aluc), .shift(shift),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .jal(jal),
        .sext(sext), .state(state), .ill(ill)
`ifdef MC_MEM_WAIT_EN
        , .mem_rdy(mem_rdy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext, ill;
        logic [1:0] alusrcb, pcsrc;
        logic [3:0] aluc;
    } sig_t;

    typedef enum logic [3:0] {C_J, C_JAL, C_JR, C_ILL, C_BEQ, C_BNE, C_LW, C_SW, C_RALU, C_IALU} cls_t;

    function automatic sig_t observe();
        sig_t o;
        o.st = state; o.wpc = wpc; o.wir = wir; o.wmem = wmem; o.wreg = wreg;
        o.iord = iord; o.regrt = regrt; o.m2reg = m2reg; o.shift = shift;
        o.alusrca = alusrca; o.jal = jal; o.sext = sext; o.ill = ill;
        o.alusrcb = alusrcb; o.pcsrc = pcsrc; o.aluc = aluc;
        return o;
    endfunction

    // Instruction set table: class, ALU operation, sign-extension, shift.
    function automatic void classify(input logic [5:0] o, input logic [5:0] f, output cls_t c,
                                     output logic [3:0] alu, output logic sx, output logic shf);
        c = C_ILL; alu = 4'b0000; sx = 1'b0; shf = 1'b0;
        case (o)
            6'h00: case (f)
                6'h20: c = C_RALU;
                6'h22: begin c = C_RALU; alu = 4'b0100; end
                6'h24: begin c = C_RALU; alu = 4'b0001; end
                6'h25: begin c = C_RALU; alu = 4'b0101; end
                6'h26: begin c = C_RALU; alu = 4'b0010; end
                6'h00: begin c = C_RALU; alu = 4'b0011; shf = 1'b1; end
                6'h02: begin c = C_RALU; alu = 4'b0111; shf = 1'b1; end
                6'h03: begin c = C_RALU; alu = 4'b1111; shf = 1'b1; end
                6'h08: c = C_JR;
                default: c = C_ILL;
            endcase
            6'h08: begin c = C_IALU; sx = 1'b1; end
            6'h0C: begin c = C_IALU; alu = 4'b0001; end
            6'h0D: begin c = C_IALU; alu = 4'b0101; end
            6'h0E: begin c = C_IALU; alu = 4'b0010; end
            6'h0F: begin c = C_IALU; alu = 4'b0110; end
            6'h23: begin c = C_LW; sx = 1'b1; end
            6'h2B: begin c = C_SW; sx = 1'b1; end
            6'h04: c = C_BEQ;
            6'h05: c = C_BNE;
            6'h02: c = C_J;
            6'h03: c = C_JAL;
            default: c = C_ILL;
        endcase
    endfunction

    function automatic int seq_len(input cls_t c);
        case (c)
            C_J, C_JAL, C_JR, C_ILL: return 2;
            C_BEQ, C_BNE:            return 3;
            C_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Every path starts IF, ID, EXE; the fourth step is MEM for loads/stores, else WB.
    function automatic logic [2:0] seq_state(input cls_t c, input int i);
        if (i < 3) return 3'(i);
        if (i == 3 && (c == C_LW || c == C_SW)) return 3'd3;
        return 3'd4;
    endfunction

    // Expected value e and care mask m for cycle i of an instruction.
    function automatic void expect_at(input logic [5:0] o, input logic [5:0] f, input logic z,
                                      input int i, output sig_t e, output sig_t m);
        cls_t c; logic [3:0] alu; logic sx, shf;
        classify(o, f, c, alu, sx, shf);
        e = '0; m = '0;
        e.st = seq_state(c, i); m.st = 3'h7;
        m.wpc = 1'b1; m.wir = 1'b1; m.wmem = 1'b1; m.wreg = 1'b1; m.ill = 1'b1; m.jal = 1'b1;
        case (e.st)
            3'd0: begin
                e.wpc = 1'b1; e.wir = 1'b1; m.iord = 1'b1; m.alusrca = 1'b1;
                m.alusrcb = 2'b11; e.alusrcb = 2'b01; m.pcsrc = 2'b11; m.aluc = 4'h7;
            end
            3'd1: begin
                m.alusrca = 1'b1; m.alusrcb = 2'b11; e.alusrcb = 2'b11;
                m.sext = 1'b1; e.sext = 1'b1; m.aluc = 4'h7;
                if (c == C_J || c == C_JAL) begin e.wpc = 1'b1; m.pcsrc = 2'b11; e.pcsrc = 2'b11; end
                if (c == C_JAL) begin e.wreg = 1'b1; e.jal = 1'b1; end
                if (c == C_JR) begin e.wpc = 1'b1; m.pcsrc = 2'b11; e.pcsrc = 2'b10; end
                if (c == C_ILL) e.ill = 1'b1;
            end
            3'd2: begin
                m.shift = 1'b1; e.shift = shf;
                if (c == C_BEQ || c == C_BNE) begin
                    e.wpc = (c == C_BEQ) ? z : !z;
                    m.alusrca = 1'b1; e.alusrca = 1'b1; m.alusrcb = 2'b11; e.alusrcb = 2'b00;
                    m.aluc = 4'h7; e.aluc = 4'b0100; m.pcsrc = 2'b11; e.pcsrc = 2'b01;
                end else if (c == C_LW || c == C_SW) begin
                    m.alusrcb = 2'b11; e.alusrcb = 2'b10; m.sext = 1'b1; e.sext = 1'b1; m.aluc = 4'h7;
                end else if (c == C_IALU) begin
                    m.alusrcb = 2'b11; e.alusrcb = 2'b10; m.aluc = 4'h7; e.aluc = alu;
                    if (o != 6'h0F) begin m.sext = 1'b1; e.sext = sx; end
                end else begin
                    m.aluc = shf ? 4'hF : 4'h7; e.aluc = alu;
                end
            end
            3'd3: begin
                m.iord = 1'b1; e.iord = 1'b1; e.wmem = (c == C_SW);
            end
            3'd4: begin
                e.wreg = 1'b1; m.regrt = 1'b1; e.regrt = (c != C_RALU);
                m.m2reg = 1'b1; e.m2reg = (c == C_LW);
            end
            default: ;
        endcase
    endfunction

    // Reset pulse ending one time unit after a rising edge, leaving a full IF cycle.
    task automatic do_reset();
        @(posedge clk); #1 clrn = 1'b0;
        @(posedge clk); #1 clrn = 1'b1;
    endtask

    task automatic test_reset();
        op = 6'h00; func = 6'h20; clrn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({state, wpc, wir, wmem, wreg} !== 7'b000_0000) begin
                errors++;
                $display("FAIL reset_hold: state=%0d wpc=%b wir=%b wmem=%b wreg=%b, want state 0 and enables 0",
                         state, wpc, wir, wmem, wreg);
            end
        end
        @(posedge clk); #1 clrn = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, wpc, wir, wmem, wreg} !== 7'b000_1100) begin
            errors++;
            $display("FAIL reset_release: state=%0d wpc=%b wir=%b wmem=%b wreg=%b, want state 0 wpc 1 wir 1",
                     state, wpc, wir, wmem, wreg);
        end
    endtask

    task automatic test_directed();
        logic [5:0] ops [17] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h04, 6'h05, 6'h05, 6'h03, 6'h3F,
                                 6'h00, 6'h00, 6'h0F, 6'h0C, 6'h02, 6'h08, 6'h00, 6'h00};
        logic [5:0] fns [17] = '{6'h20, 6'h11, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h03, 6'h21};
        logic       zs  [17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sig_t e, m, a;
        cls_t c; logic [3:0] alu; logic sx, shf;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            op = ops[k]; func = fns[k]; zero = zs[k];
            classify(op, func, c, alu, sx, shf);
            for (int i = 0; i < seq_len(c); i++) begin
                expect_at(op, func, zero, i, e, m);
                @(negedge clk);
                a = observe();
                checks++;
                if (((a ^ e) & m) !== '0) begin
                    errors++;
                    $display("FAIL directed op=%h func=%h z=%b cyc%0d: got %h want %h mask %h",
                             op, func, zero, i, a, e, m);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [5:0] legal_op [12] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        logic [5:0] rfn [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08};
        sig_t e, m, a;
        cls_t c; logic [3:0] alu; logic sx, shf;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 6'($urandom_range(0, 63)); func = 6'($urandom_range(0, 63));
            end else begin
                op = legal_op[$urandom_range(0, 11)]; func = rfn[$urandom_range(0, 8)];
            end
            classify(op, func, c, alu, sx, shf);
            for (int i = 0; i < seq_len(c); i++) begin
                zero = 1'($urandom_range(0, 1));
                expect_at(op, func, zero, i, e, m);
                @(negedge clk);
                a = observe();
                checks++;
                if (((a ^ e) & m) !== '0) begin
                    errors++;
                    $display("FAIL random op=%h func=%h z=%b cyc%0d: got %h want %h mask %h",
                             op, func, zero, i, a, e, m);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        do_reset();
        op = 6'h23; func = 6'h00;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || iord !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: state=%0d iord=%b, want state 3 iord 1", state, iord);
        end
        #1 clrn = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || wreg !== 1'b0 || wpc !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: state=%0d wreg=%b wpc=%b, want 0 0 0", state, wreg, wpc);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd0 || wreg !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_held: state=%0d wreg=%b, want 0 0", state, wreg);
        end
        clrn = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, wpc, wir, wmem, wreg} !== 7'b000_1100) begin
            errors++;
            $display("FAIL mid_reset_restart: state=%0d wpc=%b wir=%b wmem=%b wreg=%b, want 0 1 1 0 0",
                     state, wpc, wir, wmem, wreg);
        end
    endtask

`ifdef MC_MEM_WAIT_EN
    task automatic test_mem_wait();
        mem_rdy = 1'b0;
        op = 6'h00; func = 6'h20;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || wir !== 1'b0 || wpc !== 1'b0) begin
                errors++;
                $display("FAIL if_stall: state=%0d wir=%b wpc=%b, want 0 0 0", state, wir, wpc);
            end
            @(posedge clk); #1;
        end
        mem_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || wir !== 1'b1 || wpc !== 1'b1) begin
            errors++;
            $display("FAIL if_ready: state=%0d wir=%b wpc=%b, want 0 1 1", state, wir, wpc);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL if_leave: state=%0d, want 1", state);
        end
        op = 6'h2B;
        do_reset();
        repeat (3) begin @(posedge clk); #1; end
        mem_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd3 || wmem !== 1'b0) begin
                errors++;
                $display("FAIL mem_stall: state=%0d wmem=%b, want 3 0", state, wmem);
            end
            @(posedge clk); #1;
        end
        mem_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || wmem !== 1'b1) begin
            errors++;
            $display("FAIL mem_ready: state=%0d wmem=%b, want 3 1", state, wmem);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL mem_leave: state=%0d, want 0", state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_lw();
        test_back_to_back_random();
`ifdef MC_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
